// File: rtl/dca_matrix_lsu_store_sequencer.sv
// Matrix-store LSU sequencer: turns one store instruction into per-row AXI
// write transactions, bounds outstanding writes and pulses done when drained.
// Ports: clk_i/rst_i (sync, active-high); inst_* instruction handshake;
//   txn_* row transaction handshake; wresp_done_i B-response pulse;
//   busy_o while an instruction is in flight; done_o completion pulse.
module dca_matrix_lsu_store_sequencer #(
  parameter int BW_ADDR         = 32,
  parameter int BW_AXI_DATA     = 128,
  parameter int BW_ROW_IDX      = 4,
  parameter int BW_STRIDE       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  inst_valid_i,
  output logic                  inst_ready_o,
  input  logic [BW_ADDR-1:0]    inst_addr_i,
  input  logic [BW_STRIDE-1:0]  inst_stride_i,
  input  logic [BW_ROW_IDX-1:0] inst_num_row_m1_i,
  input  logic [BW_ROW_IDX-1:0] inst_num_col_m1_i,
  input  logic [1:0]            inst_elem_lsa_i,
  output logic                  txn_valid_o,
  input  logic                  txn_ready_i,
  output logic [BW_ADDR-1:0]    txn_addr_o,
  output logic [7:0]            txn_alen_o,
  output logic                  txn_first_o,
  output logic                  txn_last_o,
  output logic [BW_ROW_IDX-1:0] txn_row_idx_o,
  input  logic                  wresp_done_i,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int BPB  = BW_AXI_DATA / 8;
  localparam int OFFW = $clog2(BPB);
  localparam int CW   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [BW_ADDR-1:0]    addr_q;
  logic [BW_STRIDE-1:0]  stride_q;
  logic [BW_ROW_IDX-1:0] nrow_q;
  logic [BW_ROW_IDX-1:0] ncol_q;
  logic [1:0]            lsa_q;
  logic [BW_ROW_IDX-1:0] row_q;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic issue, can_issue, hs, resp, is_last;
  logic [31:0] row_bytes, span, beats, alen_full;

  assign issue     = (state_q == S_ISSUE);
  assign can_issue = issue && (cnt_q < CW'(MAX_OUTSTANDING));
  assign hs        = can_issue && txn_ready_i;
  // Responses with nothing outstanding are stray and ignored.
  assign resp      = wresp_done_i && (cnt_q != '0);
  assign is_last   = (row_q == nrow_q);

  // Beats covered from the row's misaligned start to its last byte.
  assign row_bytes = (32'(ncol_q) + 32'd1) << lsa_q;
  assign span      = 32'(addr_q[OFFW-1:0]) + row_bytes;
  assign beats     = (span + 32'(BPB - 1)) >> OFFW;
  assign alen_full = beats - 32'd1;

  assign txn_addr_o    = issue ? addr_q : '0;
  assign txn_alen_o    = issue ? alen_full[7:0] : '0;
  assign txn_first_o   = issue && (row_q == '0);
  assign txn_last_o    = issue && is_last;
  assign txn_row_idx_o = issue ? row_q : '0;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({hs, resp})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    inst_ready_o = 1'b0;
    txn_valid_o  = 1'b0;
    busy_o       = 1'b1;
    done_o       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        inst_ready_o = 1'b1;
        busy_o       = 1'b0;
        if (inst_valid_i) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        txn_valid_o = can_issue;
        if (hs && is_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == '0 || (cnt_q == CW'(1) && resp))
          state_d = S_DONE;
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      addr_q   <= '0;
      stride_q <= '0;
      nrow_q   <= '0;
      ncol_q   <= '0;
      lsa_q    <= '0;
      row_q    <= '0;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (state_q == S_IDLE && inst_valid_i) begin
        addr_q   <= inst_addr_i;
        stride_q <= inst_stride_i;
        nrow_q   <= inst_num_row_m1_i;
        ncol_q   <= inst_num_col_m1_i;
        lsa_q    <= inst_elem_lsa_i;
        row_q    <= '0;
      end else if (hs) begin
        addr_q <= addr_q + BW_ADDR'(stride_q);
        row_q  <= row_q + BW_ROW_IDX'(1);
      end
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_store_sequencer.sv
// Directed bench for the matrix-store sequencer: reset, alen, row walk,
// outstanding limit, coincident handshake/response and mid-drain reset.
module tb_dca_matrix_lsu_store_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_addr;
  logic [15:0] inst_stride;
  logic [3:0]  inst_nrow;
  logic [3:0]  inst_ncol;
  logic [1:0]  inst_lsa;
  logic        txn_valid;
  logic        txn_ready;
  logic [31:0] txn_addr;
  logic [7:0]  txn_alen;
  logic        txn_first;
  logic        txn_last;
  logic [3:0]  txn_row;
  logic        wresp;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dca_matrix_lsu_store_sequencer dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .inst_valid_i      (inst_valid),
    .inst_ready_o      (inst_ready),
    .inst_addr_i       (inst_addr),
    .inst_stride_i     (inst_stride),
    .inst_num_row_m1_i (inst_nrow),
    .inst_num_col_m1_i (inst_ncol),
    .inst_elem_lsa_i   (inst_lsa),
    .txn_valid_o       (txn_valid),
    .txn_ready_i       (txn_ready),
    .txn_addr_o        (txn_addr),
    .txn_alen_o        (txn_alen),
    .txn_first_o       (txn_first),
    .txn_last_o        (txn_last),
    .txn_row_idx_o     (txn_row),
    .wresp_done_i      (wresp),
    .busy_o            (busy),
    .done_o            (done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [15:0] s,
                      input logic [3:0] nr, input logic [3:0] nc,
                      input logic [1:0] l);
    inst_valid  = 1'b1;
    inst_addr   = a;
    inst_stride = s;
    inst_nrow   = nr;
    inst_ncol   = nc;
    inst_lsa    = l;
    tick();
    inst_valid  = 1'b0;
    inst_addr   = 32'hDEAD_BEEF;
    inst_nrow   = 4'hF;
  endtask

  // Accept every txn and answer every cycle until done, bounded.
  task automatic finish_all(input string nm);
    bit seen = 0;
    txn_ready = 1'b1;
    wresp     = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (done) seen = 1;
      else tick();
    end
    txn_ready = 1'b0;
    wresp     = 1'b0;
    n_chk++;
    if (!seen) begin
      $display("FAIL %s_drain: done never seen within 100 cycles", nm);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    n_chk++;
    if ({inst_ready, txn_valid, busy, done} !== 4'b1000) begin
      $display("FAIL reset_ctrl: got %b want 1000",
               {inst_ready, txn_valid, busy, done});
      n_fail++;
    end
    n_chk++;
    if ({txn_addr, txn_alen, txn_first, txn_last, txn_row} !== '0) begin
      $display("FAIL reset_data: addr=%h alen=%h f=%b l=%b row=%h want 0",
               txn_addr, txn_alen, txn_first, txn_last, txn_row);
      n_fail++;
    end
  endtask

  task automatic test_single_row();
    send(32'h1000, 16'h0, 4'd0, 4'd3, 2'd2);
    n_chk++;
    if ({txn_valid, txn_first, txn_last, inst_ready, busy} !== 5'b11101) begin
      $display("FAIL single_ctrl: got %b want 11101",
               {txn_valid, txn_first, txn_last, inst_ready, busy});
      n_fail++;
    end
    n_chk++;
    if (txn_addr !== 32'h1000 || txn_alen !== 8'd0 || txn_row !== 4'd0) begin
      $display("FAIL single_data: addr=%h alen=%0d row=%0d want 1000/0/0",
               txn_addr, txn_alen, txn_row);
      n_fail++;
    end
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    tick();
    n_chk++;
    if (txn_valid !== 1'b0 || done !== 1'b0) begin
      $display("FAIL single_drain: valid=%b done=%b want 0/0", txn_valid, done);
      n_fail++;
    end
    wresp = 1'b1;
    tick();
    wresp = 1'b0;
    n_chk++;
    if (done !== 1'b1) begin
      $display("FAIL single_done: done=%b want 1", done);
      n_fail++;
    end
    tick();
    n_chk++;
    if ({done, busy, inst_ready} !== 3'b001) begin
      $display("FAIL single_idle: got %b want 001", {done, busy, inst_ready});
      n_fail++;
    end
  endtask

  task automatic test_misaligned();
    send(32'h100C, 16'h0, 4'd0, 4'd3, 2'd2);
    n_chk++;
    if (txn_alen !== 8'd1 || txn_addr !== 32'h100C) begin
      $display("FAIL misaligned_alen: alen=%0d addr=%h want 1/100c",
               txn_alen, txn_addr);
      n_fail++;
    end
    finish_all("misaligned");
  endtask

  task automatic test_rows();
    send(32'h2000, 16'h40, 4'd2, 4'd3, 2'd2);
    txn_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      n_chk++;
      if (txn_valid !== 1'b1 || txn_addr !== 32'h2000 + 32'(r) * 32'h40 ||
          txn_row !== 4'(r) || txn_first !== (r == 0) ||
          txn_last !== (r == 2)) begin
        $display("FAIL rows_%0d: v=%b addr=%h row=%0d f=%b l=%b", r,
                 txn_valid, txn_addr, txn_row, txn_first, txn_last);
        n_fail++;
      end
      tick();
    end
    txn_ready = 1'b0;
    wresp = 1'b1;
    tick();
    tick();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL rows_early: done=%b busy=%b want 0/1", done, busy);
      n_fail++;
    end
    tick();
    wresp = 1'b0;
    n_chk++;
    if (done !== 1'b1) begin
      $display("FAIL rows_done: done=%b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_outstanding();
    int hs = 0;
    send(32'h3000, 16'h20, 4'd5, 4'd3, 2'd2);
    txn_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (txn_valid) hs++;
      tick();
    end
    n_chk++;
    if (hs != 4 || txn_valid !== 1'b0) begin
      $display("FAIL outst_limit: handshakes=%0d valid=%b want 4/0",
               hs, txn_valid);
      n_fail++;
    end
    wresp = 1'b1;
    tick();
    wresp = 1'b0;
    n_chk++;
    if (txn_valid !== 1'b1 || txn_row !== 4'd4 || txn_addr !== 32'h3080) begin
      $display("FAIL outst_resume: v=%b row=%0d addr=%h want 1/4/3080",
               txn_valid, txn_row, txn_addr);
      n_fail++;
    end
    tick();
    n_chk++;
    if (txn_valid !== 1'b0) begin
      $display("FAIL outst_restall: valid=%b want 0", txn_valid);
      n_fail++;
    end
    finish_all("outst");
  endtask

  task automatic test_back_to_back();
    send(32'h4000, 16'h10, 4'd3, 4'd7, 2'd3);
    txn_ready = 1'b1;
    tick();
    tick();
    wresp = 1'b1;
    tick();
    wresp     = 1'b0;
    txn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (txn_valid !== 1'b1 || txn_addr !== 32'h4030 || txn_alen !== 8'd3 ||
          txn_row !== 4'd3 || txn_last !== 1'b1 || txn_first !== 1'b0) begin
        $display("FAIL b2b_hold_%0d: v=%b addr=%h alen=%0d row=%0d l=%b", i,
                 txn_valid, txn_addr, txn_alen, txn_row, txn_last);
        n_fail++;
      end
      tick();
    end
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    wresp = 1'b1;
    tick();
    tick();
    wresp = 1'b0;
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b1) begin
      $display("FAIL b2b_count: done=%b busy=%b want 0/1", done, busy);
      n_fail++;
    end
    wresp = 1'b1;
    tick();
    wresp = 1'b0;
    n_chk++;
    if (done !== 1'b1) begin
      $display("FAIL b2b_done: done=%b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_drain();
    bit saw_done = 0;
    send(32'h6000, 16'h0, 4'd1, 4'd0, 2'd0);
    n_chk++;
    if (txn_addr !== 32'h6000 || txn_alen !== 8'd0) begin
      $display("FAIL stride0_r0: addr=%h alen=%0d want 6000/0",
               txn_addr, txn_alen);
      n_fail++;
    end
    txn_ready = 1'b1;
    tick();
    n_chk++;
    if (txn_addr !== 32'h6000 || txn_row !== 4'd1) begin
      $display("FAIL stride0_r1: addr=%h row=%0d want 6000/1",
               txn_addr, txn_row);
      n_fail++;
    end
    tick();
    txn_ready = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++;
    if ({inst_ready, busy, txn_valid, done} !== 4'b1000) begin
      $display("FAIL rstdrain_idle: got %b want 1000",
               {inst_ready, busy, txn_valid, done});
      n_fail++;
    end
    wresp = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done) saw_done = 1;
      tick();
    end
    wresp = 1'b0;
    n_chk++;
    if (saw_done || done !== 1'b0) begin
      $display("FAIL rstdrain_nodone: done pulse seen after reset");
      n_fail++;
    end
    send(32'h5004, 16'h0, 4'd0, 4'd15, 2'd0);
    n_chk++;
    if (txn_valid !== 1'b1 || txn_alen !== 8'd1 || txn_addr !== 32'h5004) begin
      $display("FAIL rstdrain_new: v=%b alen=%0d addr=%h want 1/1/5004",
               txn_valid, txn_alen, txn_addr);
      n_fail++;
    end
    txn_ready = 1'b1;
    tick();
    txn_ready = 1'b0;
    wresp = 1'b1;
    tick();
    wresp = 1'b0;
    n_chk++;
    if (done !== 1'b1) begin
      $display("FAIL rstdrain_done: done=%b want 1", done);
      n_fail++;
    end
    tick();
  endtask

  initial begin
    rst         = 1'b1;
    inst_valid  = 1'b0;
    inst_addr   = '0;
    inst_stride = '0;
    inst_nrow   = '0;
    inst_ncol   = '0;
    inst_lsa    = '0;
    txn_ready   = 1'b0;
    wresp       = 1'b0;
    test_reset();
    test_single_row();
    test_misaligned();
    test_rows();
    test_outstanding();
    test_back_to_back();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
